cix32_mem_arbiter: RTL and testbench

Two-requester memory-port arbiter that lets the instruction fetch unit and the load/store unit share one memory port. It sits between the fetch unit's imem-style interface, the LSU's dmem-style interface, and a single downstream req/ready memory port. It runs one transaction at a time with registered grant, gives data priority, and forces a fetch grant once fetch has been starved for a bounded number of data grants.

---
 rtl/cix32_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_cix32_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cix32_mem_arbiter.sv
// Two-requester memory-port arbiter: one transaction at a time, data has priority,
// and fetch is forced after STARVE_LIMIT data grants issued while fetch was waiting.
module cix32_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_addr,
    input  logic        if_req,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    input  logic        d_we,
    input  logic        d_req,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        mem_we,
    output logic        mem_req,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        owner
);

    typedef enum logic [1:0] {
        StIdle,
        StGntI,
        StGntD
    } state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    state_e      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        mem_we_q, mem_we_d;

    logic        is_idle;
    logic        fetch_forced;
    logic        grant_d;
    logic        grant_i;

    assign is_idle      = (state_q == StIdle);
    assign fetch_forced = if_req && (starve_q == StarveMax);
    assign grant_d      = is_idle && d_req && !fetch_forced;
    assign grant_i      = is_idle && if_req && !grant_d;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_we_d    = mem_we_q;

        unique case (state_q)
            StIdle: begin
                if (!if_req) begin
                    starve_d = '0;
                end
                if (grant_d) begin
                    state_d     = StGntD;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_wstrb_d = d_wstrb;
                    mem_we_d    = d_we;
                    // Only data grants that bypass a waiting fetch count toward starvation.
                    if (if_req && (starve_q < StarveMax)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (grant_i) begin
                    state_d     = StGntI;
                    starve_d    = '0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    mem_we_d    = 1'b0;
                end
            end
            StGntI, StGntD: begin
                if (mem_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign mem_req   = !is_idle;
    assign owner     = (state_q == StGntD);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_we    = mem_we_q;

    assign if_ready  = (state_q == StGntI) && mem_ready;
    assign d_ready   = (state_q == StGntD) && mem_ready;
    assign if_rdata  = if_ready ? mem_rdata : 32'd0;
    assign d_rdata   = d_ready ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_cix32_mem_arbiter.sv
// Randomized scoreboard bench for cix32_mem_arbiter: a transaction-level model predicts
// each grant and its captured payload; a monitor pops and checks whenever the DUT responds.
module tb_cix32_mem_arbiter;

    localparam int unsigned STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_req = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        d_we = 1'b0;
    logic        d_req = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        if_ready, d_ready, mem_we, mem_req, owner;

    always #5 clk = ~clk;

    cix32_mem_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_addr  (if_addr),
        .if_req   (if_req),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wstrb  (d_wstrb),
        .d_we     (d_we),
        .d_req    (d_req),
        .d_rdata  (d_rdata),
        .d_ready  (d_ready),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_we   (mem_we),
        .mem_req  (mem_req),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .owner    (owner)
    );

    typedef struct packed {
        logic        own;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        we;
    } txn_t;

    int   tests = 0;
    int   fails = 0;

    // Reference model state (written only by the model process)
    txn_t exp_q[$];
    bit   m_busy = 0;
    bit   m_owner = 0;
    int   m_skipped = 0;
    bit   f_granted = 0;
    bit   d_granted = 0;
    int   f_done_cnt = 0;
    int   d_done_cnt = 0;
    int   rst_cnt = 0;

    // Monitor state
    txn_t mon_cur;
    bit   mon_valid = 0;
    int   mon_rst_seen = 0;
    bit   phase_starve = 0;
    bit   grant_log[$];

    // Driver state
    bit   f_active = 0;
    bit   d_active = 0;
    int   f_seen = 0;
    int   d_seen = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: fetch is passed over by data only while it has been skipped fewer than
    // STARVE_LIMIT times since it last stopped waiting or was served.
    initial begin
        txn_t t;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_busy    = 0;
                m_owner   = 0;
                m_skipped = 0;
                f_granted = 0;
                d_granted = 0;
                rst_cnt++;
            end else if (m_busy) begin
                if (mem_ready) begin
                    m_busy = 0;
                    if (m_owner) begin
                        d_granted = 0;
                        d_done_cnt++;
                    end else begin
                        f_granted = 0;
                        f_done_cnt++;
                    end
                end
            end else begin
                if (!if_req) m_skipped = 0;
                if (d_req && !(if_req && m_skipped >= STARVE_LIMIT)) begin
                    if (if_req && m_skipped < STARVE_LIMIT) m_skipped++;
                    t = '{own: 1'b1, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb, we: d_we};
                    exp_q.push_back(t);
                    m_busy    = 1;
                    m_owner   = 1;
                    d_granted = 1;
                end else if (if_req) begin
                    m_skipped = 0;
                    t = '{own: 1'b0, addr: if_addr, wdata: 32'd0, wstrb: 4'd0, we: 1'b0};
                    exp_q.push_back(t);
                    m_busy    = 1;
                    m_owner   = 0;
                    f_granted = 1;
                end
            end
        end
    end

    // Monitor: samples on the falling edge, pops a scoreboard entry on each new grant.
    initial begin
        bit exp_if, exp_d;
        forever begin
            @(negedge clk);
            if (rst_cnt != mon_rst_seen) begin
                mon_rst_seen = rst_cnt;
                mon_valid    = 0;
                exp_q.delete();
                chk("reset_regs", 128'({mem_req, mem_we, owner, mem_addr, mem_wdata, mem_wstrb}),
                    128'd0);
            end
            chk("mem_req", 128'(mem_req), 128'(m_busy));
            if (mem_req && !mon_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_grant: got mem_req=1 expected no grant at %0t",
                             $time);
                end else begin
                    mon_cur   = exp_q.pop_front();
                    mon_valid = 1;
                    if (phase_starve) grant_log.push_back(owner);
                end
            end
            if (mon_valid) begin
                chk("owner", 128'(owner), 128'(mon_cur.own));
                chk("mem_addr", 128'(mem_addr), 128'(mon_cur.addr));
                chk("mem_wdata", 128'(mem_wdata), 128'(mon_cur.wdata));
                chk("mem_wstrb", 128'(mem_wstrb), 128'(mon_cur.wstrb));
                chk("mem_we", 128'(mem_we), 128'(mon_cur.we));
            end else begin
                chk("owner_idle", 128'(owner), 128'd0);
            end
            exp_if = mon_valid && !mon_cur.own && mem_ready;
            exp_d  = mon_valid && mon_cur.own && mem_ready;
            chk("if_ready", 128'(if_ready), 128'(exp_if));
            chk("d_ready", 128'(d_ready), 128'(exp_d));
            chk("if_rdata", 128'(if_rdata), exp_if ? 128'(mem_rdata) : 128'd0);
            chk("d_rdata", 128'(d_rdata), exp_d ? 128'(mem_rdata) : 128'd0);
            if (mon_valid && mem_ready) mon_valid = 0;
        end
    end

    // One cycle of requester and memory behaviour, driven 2 time units after posedge.
    task automatic cycle(input int pf, input int pd, input int prdy, input int pspur);
        @(posedge clk);
        #2;
        if (f_done_cnt != f_seen) begin
            f_seen   = f_done_cnt;
            f_active = 0;
            if_req   = 0;
        end
        if (!f_active) begin
            if_addr = $urandom;
            if (int'($urandom_range(99)) < pf) begin
                f_active = 1;
                if_req   = 1;
            end
        end else if (f_granted && $urandom_range(3) == 0) begin
            if_addr = $urandom;
            if ($urandom_range(1) == 1) if_req = 0;
        end

        if (d_done_cnt != d_seen) begin
            d_seen   = d_done_cnt;
            d_active = 0;
            d_req    = 0;
        end
        if (!d_active) begin
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_wstrb = 4'($urandom);
            d_we    = 1'($urandom);
            if (int'($urandom_range(99)) < pd) begin
                d_active = 1;
                d_req    = 1;
            end
        end else if (d_granted && $urandom_range(3) == 0) begin
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_wstrb = 4'($urandom);
            d_we    = ~d_we;
            if ($urandom_range(1) == 1) d_req = 0;
        end

        mem_rdata = $urandom;
        if (m_busy) mem_ready = int'($urandom_range(99)) < prdy;
        else        mem_ready = int'($urandom_range(99)) < pspur;
    endtask

    initial begin
        bit found;
        repeat (2) cycle(0, 0, 0, 0);
        rst_n = 1;

        // Both requesters saturated against a zero-wait memory.
        phase_starve = 1;
        repeat (60) cycle(100, 100, 100, 0);
        phase_starve = 0;
        if (grant_log.size() < 2 * (STARVE_LIMIT + 1)) begin
            tests++;
            fails++;
            $display("FAIL starve_log_len: got %0d grants expected at least %0d",
                     grant_log.size(), 2 * (STARVE_LIMIT + 1));
        end
        foreach (grant_log[k]) begin
            chk("starve_seq", 128'(grant_log[k]),
                (k % (STARVE_LIMIT + 1) == STARVE_LIMIT) ? 128'd0 : 128'd1);
        end

        repeat (600) cycle(40, 40, 50, 10);
        repeat (300) cycle(30, 50, 20, 20);

        // Abort an in-flight data transaction with reset.
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            cycle(0, 60, 30, 0);
            if (m_busy && m_owner) found = 1;
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL reset_mid_setup: got no data grant expected one within 300 cycles");
        end
        mem_ready = 0;
        rst_n     = 0;
        if_req    = 0;
        d_req     = 0;
        f_active  = 0;
        d_active  = 0;
        @(posedge clk);
        #2;
        rst_n = 1;

        // Idle with spurious mem_ready pulses.
        repeat (40) cycle(0, 0, 0, 50);

        repeat (400) cycle(50, 50, 60, 15);
        repeat (20) cycle(0, 0, 100, 0);

        @(negedge clk);
        #1;
        chk("drain_queue", 128'(exp_q.size()), 128'd0);
        chk("drain_idle", 128'({mon_valid, mem_req}), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
